uart_tx_arbiter: RTL and testbench

//   Shares the single UART transmitter of the single_cycle CPU between two byte

---
 rtl/uart_tx_arbiter.sv | 141 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between two byte sources. Source 0 is the CPU TX
//   register store and source 1 is the RX echo/debug path. When both sources are
//   valid they are served in strict round-robin order. The arbiter latches the
//   winning byte and pulses tx_start for one cycle. It then follows the
//   transmitter's busy handshake until the frame is complete. A sticky error is
//   raised if the transmitter never acknowledges or never finishes.
//
// Ports
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   reqN_valid/data/ready  source N handshake; ready pulses for the accepted cycle
//   tx_start, tx_data      one-cycle start pulse and byte held until back in idle
//   tx_busy                transmitter frame-in-progress flag
//   arb_busy               high whenever the arbiter owns the transmitter
//   grant_id               source of the current or last transfer
//   err_timeout, err_clr   sticky ack/done timeout flag and its clear
module uart_tx_arbiter #(
    parameter int unsigned ACK_TIMEOUT  = 16,
    parameter int unsigned DONE_TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    output logic       arb_busy,
    output logic       grant_id,
    output logic       err_timeout,
    input  logic       err_clr
);

    localparam int unsigned MaxTimeout = (ACK_TIMEOUT > DONE_TIMEOUT) ? ACK_TIMEOUT
                                                                      : DONE_TIMEOUT;
    localparam int unsigned CntW = $clog2(MaxTimeout + 1);
    localparam logic [CntW-1:0] AckLast  = CntW'(ACK_TIMEOUT - 1);
    localparam logic [CntW-1:0] DoneLast = CntW'(DONE_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StLaunch, StWaitAck, StWaitDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      data_q, data_d;
    logic            gid_q, gid_d;
    logic            last_q, last_d;
    logic            err_q, err_d;
    logic            pick1;
    logic            set_err;

    // Source 1 wins if it is the only one asking, or if both ask and source 0
    // had the last turn.
    assign pick1 = req1_valid && (!req0_valid || !last_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        gid_d      = gid_q;
        last_d     = last_q;
        err_d      = err_q;
        set_err    = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        tx_start   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Ready is masked during reset so no byte is acknowledged and then dropped.
                if (!reset && (req0_valid || req1_valid)) begin
                    req0_ready = !pick1;
                    req1_ready = pick1;
                    data_d     = pick1 ? req1_data : req0_data;
                    gid_d      = pick1;
                    last_d     = pick1;
                    cnt_d      = '0;
                    state_d    = StLaunch;
                end
            end
            StLaunch: begin
                // tx_busy is deliberately not sampled here.
                tx_start = 1'b1;
                state_d  = StWaitAck;
            end
            StWaitAck: begin
                if (tx_busy) begin
                    cnt_d   = '0;
                    state_d = StWaitDone;
                end else if (cnt_q == AckLast) begin
                    set_err = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (!tx_busy) begin
                    state_d = StIdle;
                end else if (cnt_q == DoneLast) begin
                    set_err = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A new timeout takes priority over a simultaneous clear.
        if (err_clr) err_d = 1'b0;
        if (set_err) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            data_q  <= '0;
            gid_q   <= 1'b0;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            gid_q   <= gid_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign arb_busy    = (state_q != StIdle);
    assign tx_data     = data_q;
    assign grant_id    = gid_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter. A timestamp-based reference model predicts every
// output on every cycle. Directed scenarios pin the model with literal values,
// and a randomized phase exercises sources, the transmitter and error clears.
module tb_uart_tx_arbiter;

    localparam int unsigned AckTo  = 16;
    localparam int unsigned DoneTo = 32;

    typedef enum int {SrcOff, SrcHold, SrcOnce, SrcRand} src_mode_e;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       src_vld [2];
    logic [7:0] src_dat [2];
    logic       tx_busy = 1'b0;
    logic       err_clr = 1'b0;
    logic       req0_ready, req1_ready, tx_start, arb_busy, grant_id, err_timeout;
    logic [7:0] tx_data;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_arbiter #(
        .ACK_TIMEOUT  (AckTo),
        .DONE_TIMEOUT (DoneTo)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (src_vld[0]),
        .req0_data   (src_dat[0]),
        .req0_ready  (req0_ready),
        .req1_valid  (src_vld[1]),
        .req1_data   (src_dat[1]),
        .req1_ready  (req1_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .arb_busy    (arb_busy),
        .grant_id    (grant_id),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    bit run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one transfer in flight, tracked by the cycle numbers of
    // its launch and of its acknowledge.
    bit         m_active = 0;
    int         m_launch = 0;
    int         m_ack    = -1;
    logic [7:0] m_data   = 8'h00;
    logic       m_gid    = 1'b0;
    logic       m_last   = 1'b1;
    logic       m_err    = 1'b0;
    bit         acc [2];
    bit         tx_go = 0;

    always @(negedge clk) begin
        logic w0, w1, set_err;
        w0 = 1'b0;
        w1 = 1'b0;
        set_err = 1'b0;
        if (run) begin
            if (reset) begin
                m_active = 0;
                m_data   = 8'h00;
                m_gid    = 1'b0;
                m_last   = 1'b1;
                m_err    = 1'b0;
                check("rst_req0_ready", req0_ready, 1'b0);
                check("rst_req1_ready", req1_ready, 1'b0);
                check("rst_tx_start", tx_start, 1'b0);
                check("rst_arb_busy", arb_busy, 1'b0);
                check("rst_tx_data", tx_data, 8'h00);
                check("rst_grant_id", grant_id, 1'b0);
                check("rst_err_timeout", err_timeout, 1'b0);
            end else begin
                if (!m_active) begin
                    if (src_vld[0] && src_vld[1]) begin
                        w0 = m_last;
                        w1 = !m_last;
                    end else begin
                        w0 = src_vld[0];
                        w1 = src_vld[1];
                    end
                end
                check("req0_ready", req0_ready, w0);
                check("req1_ready", req1_ready, w1);
                check("tx_start", tx_start, m_active && (cyc == m_launch));
                check("arb_busy", arb_busy, m_active);
                check("tx_data", tx_data, m_data);
                check("grant_id", grant_id, m_gid);
                check("err_timeout", err_timeout, m_err);

                if (!m_active) begin
                    if (w0 || w1) begin
                        m_active = 1;
                        m_launch = cyc + 1;
                        m_ack    = -1;
                        m_gid    = w1;
                        m_last   = w1;
                        m_data   = w1 ? src_dat[1] : src_dat[0];
                        if (w1) acc[1] = 1;
                        else    acc[0] = 1;
                        tx_go = 1;
                    end
                end else if (cyc > m_launch) begin
                    if (m_ack < 0) begin
                        if (tx_busy) m_ack = cyc;
                        else if (cyc - m_launch == AckTo) begin
                            set_err  = 1'b1;
                            m_active = 0;
                        end
                    end else begin
                        if (!tx_busy) m_active = 0;
                        else if (cyc - m_ack == DoneTo) begin
                            set_err  = 1'b1;
                            m_active = 0;
                        end
                    end
                end
                if (err_clr) m_err = 1'b0;
                if (set_err) m_err = 1'b1;
            end
        end
        cyc++;
    end

    // Transmitter model: busy rises some cycles after launch for some length.
    int tx_on = 0;
    int tx_off = 0;
    int tx_mode = 1;    // 0 scheduled, 1 stuck low, 2 stuck high
    bit use_fixed = 1;
    int fix_delay = 2;
    int fix_len = 10;

    always @(posedge clk) begin
        int d, len;
        #1;
        if (tx_go) begin
            tx_go = 0;
            if (use_fixed) begin
                d   = fix_delay;
                len = fix_len;
            end else begin
                d = int'($urandom_range(0, 4));
                case ($urandom_range(0, 9))
                    0:       len = 0;
                    1:       len = DoneTo + 8;
                    default: len = int'($urandom_range(1, 8));
                endcase
            end
            tx_on  = cyc + d;
            tx_off = tx_on + len;
        end
        case (tx_mode)
            1:       tx_busy = 1'b0;
            2:       tx_busy = 1'b1;
            default: tx_busy = (cyc >= tx_on) && (cyc < tx_off);
        endcase
    end

    // Byte sources.
    src_mode_e  src_mode [2];
    logic [7:0] src_fix [2];
    int         gap [2];

    always @(posedge clk) begin
        #1;
        for (int s = 0; s < 2; s++) begin
            if (acc[s]) begin
                acc[s] = 0;
                if (src_mode[s] == SrcOnce) begin
                    src_vld[s]  = 1'b0;
                    src_mode[s] = SrcOff;
                end else if (src_mode[s] == SrcRand) begin
                    src_vld[s] = 1'b0;
                    gap[s]     = int'($urandom_range(0, 5));
                end
            end else begin
                case (src_mode[s])
                    SrcOff: src_vld[s] = 1'b0;
                    SrcHold, SrcOnce: begin
                        src_vld[s] = 1'b1;
                        src_dat[s] = src_fix[s];
                    end
                    default: begin
                        if (!src_vld[s]) begin
                            if (gap[s] == 0) begin
                                src_vld[s] = 1'b1;
                                src_dat[s] = 8'($urandom);
                            end else begin
                                gap[s]--;
                            end
                        end else if ($urandom_range(0, 19) == 0) begin
                            src_vld[s] = 1'b0;    // withdraw before grant
                        end
                    end
                endcase
            end
        end
    end

    task automatic pulse_reset();
        src_mode[0] = SrcOff;
        src_mode[1] = SrcOff;
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #3 reset = 1'b0;
    endtask

    // Returns at the negedge of the tx_start cycle, or after a bounded wait.
    task automatic wait_start(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!tx_start && k < 100);
        check(name, tx_start, 1'b1);
    endtask

    logic [7:0] t2_data [4] = '{8'h11, 8'h22, 8'h11, 8'h22};
    logic       t2_gid  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_rdy, n_start, r_cyc, s_cyc, last_busy, last_arb, got, dbl;
        logic [7:0] s_data;
        logic prev0, prev1;

        for (int s = 0; s < 2; s++) begin
            src_vld[s]  = 1'b0;
            src_dat[s]  = 8'h00;
            src_mode[s] = SrcOff;
            src_fix[s]  = 8'h00;
            gap[s]      = 0;
            acc[s]      = 0;
        end
        @(posedge clk);
        run = 1;
        @(posedge clk);
        #3 reset = 1'b0;

        // Single source 0 byte; busy rises 2 cycles after start for 10 cycles.
        use_fixed = 1; fix_delay = 2; fix_len = 10; tx_mode = 0;
        src_fix[0] = 8'h41; src_mode[0] = SrcOnce;
        n_rdy = 0; n_start = 0; r_cyc = -100; s_cyc = -100; last_busy = -100;
        last_arb = -100; s_data = 8'h00;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (req0_ready) begin n_rdy++; r_cyc = k; end
            if (tx_start) begin n_start++; s_cyc = k; s_data = tx_data; end
            if (tx_busy) last_busy = k;
            if (arb_busy) last_arb = k;
        end
        check("t1_ready_pulses", n_rdy, 1);
        check("t1_start_pulses", n_start, 1);
        check("t1_start_latency", s_cyc - r_cyc, 1);
        check("t1_tx_data", s_data, 8'h41);
        check("t1_arb_release", last_arb - last_busy, 1);
        check("t1_busy_span", last_arb - s_cyc, 12);

        // Both sources held valid: strict alternation starting with source 0.
        pulse_reset();
        fix_delay = 1; fix_len = 3;
        src_fix[0] = 8'h11; src_fix[1] = 8'h22;
        src_mode[0] = SrcHold; src_mode[1] = SrcHold;
        got = 0; dbl = 0; prev0 = 1'b0; prev1 = 1'b0;
        for (int k = 0; k < 200 && got < 4; k++) begin
            @(negedge clk);
            if ((req0_ready && prev0) || (req1_ready && prev1)) dbl++;
            prev0 = req0_ready;
            prev1 = req1_ready;
            if (tx_start) begin
                check($sformatf("t2_grant%0d", got), grant_id, t2_gid[got]);
                check($sformatf("t2_data%0d", got), tx_data, t2_data[got]);
                got++;
            end
        end
        check("t2_transfers", got, 4);
        check("t2_ready_width", dbl, 0);

        // Acknowledge timeout, then a normal transfer with the error still set.
        pulse_reset();
        tx_mode = 1;
        src_fix[0] = 8'h55; src_mode[0] = SrcOnce;
        wait_start("t3_start");
        repeat (16) @(negedge clk);
        check("t3_err_before", err_timeout, 1'b0);
        check("t3_busy_before", arb_busy, 1'b1);
        @(negedge clk);
        check("t3_err_set", err_timeout, 1'b1);
        check("t3_idle", arb_busy, 1'b0);
        tx_mode = 0; fix_delay = 1; fix_len = 3;
        src_fix[0] = 8'h66; src_mode[0] = SrcOnce;
        wait_start("t3_next_start");
        check("t3_next_data", tx_data, 8'h66);
        repeat (8) @(negedge clk);
        check("t3_next_done", arb_busy, 1'b0);
        check("t3_err_sticky", err_timeout, 1'b1);

        // Done timeout with busy stuck high.
        pulse_reset();
        tx_mode = 2;
        src_fix[0] = 8'h77; src_mode[0] = SrcOnce;
        wait_start("t4_start");
        repeat (33) @(negedge clk);
        check("t4_err_before", err_timeout, 1'b0);
        check("t4_busy_before", arb_busy, 1'b1);
        @(negedge clk);
        check("t4_err_set", err_timeout, 1'b1);
        check("t4_idle", arb_busy, 1'b0);
        tx_mode = 1;

        // Clear coinciding with a new timeout loses; clear alone wins.
        src_fix[0] = 8'h12; src_mode[0] = SrcOnce;
        wait_start("t5_start");
        repeat (15) @(negedge clk);
        @(posedge clk); #2 err_clr = 1'b1;
        @(negedge clk);
        @(posedge clk); #2 err_clr = 1'b0;
        @(negedge clk);
        check("t5_set_wins", err_timeout, 1'b1);
        check("t5_idle", arb_busy, 1'b0);
        @(posedge clk); #2 err_clr = 1'b1;
        @(negedge clk);
        check("t5_clr_pending", err_timeout, 1'b1);
        @(posedge clk); #2 err_clr = 1'b0;
        @(negedge clk);
        check("t5_cleared", err_timeout, 1'b0);

        // Asynchronous reset during a frame, with both sources waiting.
        pulse_reset();
        tx_mode = 2;
        src_fix[0] = 8'h33; src_mode[0] = SrcOnce;
        wait_start("t6_start");
        src_fix[0] = 8'h11; src_fix[1] = 8'h22;
        src_mode[0] = SrcHold; src_mode[1] = SrcHold;
        repeat (5) @(negedge clk);
        check("t6_pre_busy", arb_busy, 1'b1);
        check("t6_pre_data", tx_data, 8'h33);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("t6_async_busy", arb_busy, 1'b0);
        check("t6_async_data", tx_data, 8'h00);
        check("t6_async_grant", grant_id, 1'b0);
        check("t6_async_ready0", req0_ready, 1'b0);
        check("t6_async_ready1", req1_ready, 1'b0);
        tx_mode = 0; fix_delay = 1; fix_len = 3;
        @(posedge clk);
        #3 reset = 1'b0;
        wait_start("t6_first_start");
        check("t6_first_grant", grant_id, 1'b0);
        check("t6_first_data", tx_data, 8'h11);
        wait_start("t6_second_start");
        check("t6_second_grant", grant_id, 1'b1);
        check("t6_second_data", tx_data, 8'h22);

        // Randomized traffic with occasional clears and resets.
        pulse_reset();
        use_fixed = 0; tx_mode = 0;
        src_mode[0] = SrcRand; src_mode[1] = SrcRand;
        for (int k = 0; k < 4000; k++) begin
            @(posedge clk);
            #2 err_clr = ($urandom_range(0, 29) == 0);
            if (k == 1500 || k == 3000) #1 reset = 1'b1;
            if (k == 1502 || k == 3002) #1 reset = 1'b0;
        end
        err_clr = 1'b0;
        src_mode[0] = SrcOff; src_mode[1] = SrcOff;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
